// File: rtl/e_mul_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage. It owns the HI/LO registers,
// runs mult/multu/div/divu over a fixed busy window, and serves mfhi/mflo/mthi/mtlo.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no operation in flight, busy=0, mthi/mtlo accepted
// S_RUN  | operation in flight, busy=1, cnt counts remaining busy cycles
module e_mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;
  localparam logic [3:0] OP_MTHI = 4'b0110;
  localparam logic [3:0] OP_MTLO = 4'b0111;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [1:0]    op_q;
  logic [31:0]   hi;
  logic [31:0]   lo;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic        [31:0] res_hi;
  logic        [31:0] res_lo;
  logic               res_we;

  assign sa     = a_q;
  assign sb     = b_q;
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Result of the latched operation; only committed on the last busy cycle.
  // A zero divisor leaves res_we low so HI/LO keep their old values.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (op_q)
      2'b00: begin
        {res_hi, res_lo} = prod_s;
        res_we = 1'b1;
      end
      2'b01: begin
        {res_hi, res_lo} = prod_u;
        res_we = 1'b1;
      end
      2'b10: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          // Most-negative / -1 overflows; pin the result instead of relying on the operator.
          if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
          end else begin
            res_lo = sa / sb;
            res_hi = sa % sb;
          end
        end
      end
      default: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
    endcase
  end

  // Control FSM with registered busy; also the single writer of HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (MDOp[3:2] == 2'b00) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= MDOp[1:0];
              cnt   <= MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end else if (MDOp == OP_MTHI) begin
            hi <= A;
          end else if (MDOp == OP_MTLO) begin
            lo <= A;
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency read port; a same-cycle mthi/mtlo is not forwarded.
  always_comb begin
    case (MDOp)
      OP_MFHI: MDOut = hi;
      OP_MFLO: MDOut = lo;
      default: MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mul_div_unit.sv
// Self-checking bench for e_mul_div_unit: directed scenarios plus a randomized
// run checked against an arithmetic reference model of HI/LO.
module tb_e_mul_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] MULT  = 4'b0000;
  localparam logic [3:0] MULTU = 4'b0001;
  localparam logic [3:0] DIV   = 4'b0010;
  localparam logic [3:0] DIVU  = 4'b0011;
  localparam logic [3:0] MFHI  = 4'b0100;
  localparam logic [3:0] MFLO  = 4'b0101;
  localparam logic [3:0] MTHI  = 4'b0110;
  localparam logic [3:0] MTLO  = 4'b0111;
  localparam logic [3:0] NONE  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] MDOut;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  e_mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .MDOut (MDOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [3:0] op, output logic [31:0] v);
    logic [3:0] saved;
    saved = MDOp;
    MDOp = op;
    #1;
    v = MDOut;
    MDOp = saved;
    #1;
  endtask

  // Reference behaviour of a completed operation, from plain arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    logic [31:0] ma, mb, q, r;
    case (op)
      MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        {exp_hi, exp_lo} = ps;
      end
      MULTU: begin
        pu = 64'(a) * 64'(b);
        {exp_hi, exp_lo} = pu;
      end
      DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            exp_lo = 32'h8000_0000;
            exp_hi = 32'd0;
          end else begin
            ma = a[31] ? (32'd0 - a) : a;
            mb = b[31] ? (32'd0 - b) : b;
            q = ma / mb;
            r = ma % mb;
            exp_lo = (a[31] ^ b[31]) ? (32'd0 - q) : q;
            exp_hi = a[31] ? (32'd0 - r) : r;
          end
        end
      end
      default: begin
        if (b != 0) begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
    endcase
  endtask

  // Launch one MD op and count busy cycles (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start = 1'b1; MDOp = op; A = a; B = b;
    tick();
    start = 1'b0; MDOp = NONE;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic write_reg(input logic [3:0] op, input logic [31:0] v);
    start = 1'b0; MDOp = op; A = v;
    tick();
    MDOp = NONE;
    if (op == MTHI) exp_hi = v; else exp_lo = v;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; start = 1'b0; MDOp = MTHI; A = 32'hDEAD_BEEF; B = 32'd0;
    tick(); tick();
    reset = 1'b0; MDOp = NONE;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    read_reg(MFHI, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", v); end
    read_reg(MFLO, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", v); end
    checks++;
    if (MDOut !== 32'd0) begin errors++; $display("FAIL mdout_none: got %h expected 00000000", MDOut); end
  endtask

  task automatic test_directed_op(input string name, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input int nexp);
    int n;
    logic [31:0] v;
    run_op(op, a, b, n);
    model_op(op, a, b);
    checks++;
    if (n !== nexp) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, n, nexp); end
    read_reg(MFHI, v);
    checks++;
    if (v !== exp_hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", name, v, exp_hi); end
    read_reg(MFLO, v);
    checks++;
    if (v !== exp_lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", name, v, exp_lo); end
  endtask

  task automatic test_mult();
    test_directed_op("mult_neg1x2", MULT, 32'hFFFF_FFFF, 32'd2, MULT_N);
    checks++;
    if (exp_hi !== 32'hFFFF_FFFF || exp_lo !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL model_mult: got %h_%h expected ffffffff_fffffffe", exp_hi, exp_lo);
    end
    test_directed_op("multu_max2", MULTU, 32'hFFFF_FFFF, 32'd2, MULT_N);
  endtask

  task automatic test_div();
    test_directed_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
    checks++;
    if (exp_hi !== 32'hFFFF_FFFF || exp_lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL model_div: got %h_%h expected ffffffff_fffffffd", exp_hi, exp_lo);
    end
    test_directed_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    test_directed_op("divu_big", DIVU, 32'hFFFF_FFF9, 32'd2, DIV_N);
  endtask

  task automatic test_div_zero();
    write_reg(MTHI, 32'h11);
    write_reg(MTLO, 32'h22);
    test_directed_op("divu_by0", DIVU, 32'd7, 32'd0, DIV_N);
    checks++;
    if (exp_hi !== 32'h11 || exp_lo !== 32'h22) begin
      errors++; $display("FAIL model_div0: got %h_%h expected 00000011_00000022", exp_hi, exp_lo);
    end
    test_directed_op("div_by0", DIV, 32'h8000_0000, 32'd0, DIV_N);
  endtask

  task automatic test_move();
    logic [31:0] v;
    write_reg(MTHI, 32'h1234);
    read_reg(MFHI, v);
    checks++;
    if (v !== 32'h1234) begin errors++; $display("FAIL mthi_mfhi: got %h expected 00001234", v); end
    // mtlo together with start is not a move
    start = 1'b1; MDOp = MTLO; A = 32'h5555_5555;
    tick();
    start = 1'b0; MDOp = NONE;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_non_md_busy: got %b expected 0", busy); end
    read_reg(MFLO, v);
    checks++;
    if (v !== exp_lo) begin errors++; $display("FAIL start_mtlo_ignored: got %h expected %h", v, exp_lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] v;
    logic [31:0] a1, b1;
    a1 = $urandom; b1 = $urandom;
    start = 1'b1; MDOp = MULT; A = a1; B = b1;
    tick();
    start = 1'b0; MDOp = NONE;
    n = 0;
    for (int i = 1; i <= 40 && busy === 1'b1; i++) begin
      n++;
      case (i)
        2: begin start = 1'b1; MDOp = MULT; A = 32'h7; B = 32'h9; end
        3: begin start = 1'b0; MDOp = MTHI; A = 32'hDEAD; end
        default: begin start = 1'b0; MDOp = NONE; end
      endcase
      tick();
    end
    start = 1'b0; MDOp = NONE;
    model_op(MULT, a1, b1);
    checks++;
    if (n !== MULT_N) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", n, MULT_N); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_second_op: got %b expected 0", busy); end
    read_reg(MFHI, v);
    checks++;
    if (v !== exp_hi) begin errors++; $display("FAIL b2b_hi: got %h expected %h", v, exp_hi); end
    read_reg(MFLO, v);
    checks++;
    if (v !== exp_lo) begin errors++; $display("FAIL b2b_lo: got %h expected %h", v, exp_lo); end
  endtask

  task automatic test_random();
    int n, sel, nexp;
    logic [3:0] op;
    logic [31:0] a, b, v;
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) begin a = $urandom_range(0, 40); b = 32'd0 - $urandom_range(1, 9); end
      if (sel == 3) write_reg(($urandom_range(0, 1) == 0) ? MTHI : MTLO, $urandom);
      op = 4'($urandom_range(0, 3));
      nexp = (op == DIV || op == DIVU) ? DIV_N : MULT_N;
      run_op(op, a, b, n);
      model_op(op, a, b);
      checks++;
      if (n !== nexp) begin errors++; $display("FAIL rand_busy op=%0d: got %0d expected %0d", op, n, nexp); end
      read_reg(MFHI, v);
      checks++;
      if (v !== exp_hi) begin errors++; $display("FAIL rand_hi op=%0d a=%h b=%h: got %h expected %h", op, a, b, v, exp_hi); end
      read_reg(MFLO, v);
      checks++;
      if (v !== exp_lo) begin errors++; $display("FAIL rand_lo op=%0d a=%h b=%h: got %h expected %h", op, a, b, v, exp_lo); end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] vh, vl;
    start = 1'b1; MDOp = MULT; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0; MDOp = NONE;
    tick();
    tick();
    reset = 1'b1; MDOp = MTHI; A = 32'hABCD;
    tick();
    reset = 1'b0; MDOp = NONE;
    exp_hi = 32'd0; exp_lo = 32'd0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy c%0d: got %b expected 0", i, busy); end
      read_reg(MFHI, vh);
      read_reg(MFLO, vl);
      checks++;
      if (vh !== 32'd0 || vl !== 32'd0) begin
        errors++; $display("FAIL midreset_hilo c%0d: got %h_%h expected 00000000_00000000", i, vh, vl);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDOp = NONE; A = '0; B = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_move();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
